fifo_rd_stream: RTL and testbench



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_stream_if.sv | 16 +
 rtl/fifo_rd_stream_buf2.sv | 76 +++++++
 rtl/fifo_rd_stream.sv | 85 ++++++++
 tb/tb_fifo_rd_stream.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream adapter.
// Buffer occupancy states and counter widths live here so both sides agree.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int BEAT_CNT_W  = 16;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    BUF_EMPTY = ST_EMPTY,
    BUF_ONE   = ST_ONE,
    BUF_TWO   = ST_TWO
  } buf_state_t;

  // Buffer slots that will be occupied once the in-flight word lands and the
  // current pop retires; the read issue logic keeps this below two.
  function automatic logic [2:0] occupancy(buf_state_t s, logic inflight, logic pop);
    return {1'b0, s} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Output stream bundle of the FIFO read adapter.
// Handshake: a beat transfers on a rising clock edge where m_valid && m_ready;
// once m_valid is high, m_data/m_last hold and m_valid stays high until that transfer.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/fifo_rd_stream_buf2.sv
// stream_buf2: two-entry registered buffer with occupancy state EMPTY/ONE/TWO.
// Head is always a register, so the stream data never sees fifo_dout combinationally.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output buf_state_t            state
);

  buf_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Flush wins over any write arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (wr) begin
            head_d  = wr_data;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (wr && pop) begin
            head_d = wr_data;
          end else if (wr) begin
            tail_d  = wr_data;
            state_d = BUF_TWO;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  assign head  = head_q;
  assign state = state_q;

  a_no_wr_in_two: assert property (@(posedge rd_clk) disable iff (!rst_n)
    !(wr && state_q == BUF_TWO));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads and presents words as a valid/ready stream.
// Define FIFO_RD_STREAM_LAST_EN to generate m_last every PKT_LEN beats.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W,
  parameter int PKT_LEN    = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  fifo_rd_stream_if.master      m,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output buf_state_t            buf_state
);

  logic                  inflight_q;
  logic                  m_valid_w;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;

  assign m_valid_w = (buf_state != BUF_EMPTY);
  assign pop       = m_valid_w && m.m_ready;

  // m_ready reaches the read request only through the single pop term.
  // rst_n gates it so no read is issued while the block is held in reset.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush &&
                      (occupancy(buf_state, inflight_q, pop) < 3'd2);

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (pop) beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .rd_clk  (rd_clk),
    .rst_n   (rst_n),
    .wr      (inflight_q),
    .wr_data (fifo_dout),
    .pop     (pop),
    .flush   (flush),
    .head    (head),
    .state   (buf_state)
  );

  assign m.m_valid = m_valid_w;
  assign m.m_data  = head;
  assign beat_cnt  = beat_cnt_q;

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  // Index of the beat currently at the head of the stream.
  logic [IDX_W-1:0] pkt_idx_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_idx_q <= '0;
    end else if (flush) begin
      pkt_idx_q <= '0;
    end else if (pop) begin
      pkt_idx_q <= (pkt_idx_q == LAST_IDX) ? '0 : pkt_idx_q + 1'b1;
    end
  end

  assign m.m_last = m_valid_w && (pkt_idx_q == LAST_IDX);
`else
  assign m.m_last = 1'b0;
`endif

  a_pkt_len: assert property (@(posedge rd_clk) PKT_LEN >= 1);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a registered-read FIFO model.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;

  logic                  rd_clk = 1'b0;
  logic                  rst_n;
  logic                  fifo_empty;
  logic [DW-1:0]         fifo_dout;
  logic                  fifo_rd_en;
  logic                  flush;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  buf_state_t            buf_state;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) m_if ();

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (4)
  ) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m          (m_if),
    .beat_cnt   (beat_cnt),
    .buf_state  (buf_state)
  );

  // ---------------- clock ----------------
  always #5 rd_clk = ~rd_clk;

  // ---------------- FIFO model: one-cycle registered read ----------------
  logic [DW-1:0] mem [0:63];
  int wr_ptr;
  int rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge after inputs are set; checks, then advances one cycle.
  task automatic step(input string tag, input logic e_rd, input logic e_v,
                      input logic [DW-1:0] e_d, input int e_beat, input int e_st);
    #1;
    chk({tag, ".rd_en"}, fifo_rd_en, e_rd);
    chk({tag, ".valid"}, m_if.m_valid, e_v);
    if (e_v) chk({tag, ".data"}, m_if.m_data, e_d);
    if (e_beat >= 0) chk({tag, ".beat"}, beat_cnt, e_beat);
    if (e_st >= 0) chk({tag, ".state"}, buf_state, e_st);
`ifndef FIFO_RD_STREAM_LAST_EN
    chk({tag, ".last"}, m_if.m_last, 1'b0);
`endif
    @(negedge rd_clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int post;
    logic flushed;

    rst_n = 1'b0;
    flush = 1'b0;
    m_if.m_ready = 1'b1;
    wr_ptr = 0;
    push(8'h11); push(8'h22); push(8'h33);

    // Reset values with a non-empty FIFO
    @(negedge rd_clk); @(negedge rd_clk);
    #1;
    chk("rst.rd_en", fifo_rd_en, 1'b0);
    chk("rst.valid", m_if.m_valid, 1'b0);
    chk("rst.data", m_if.m_data, 8'h00);
    chk("rst.last", m_if.m_last, 1'b0);
    chk("rst.beat", beat_cnt, 16'd0);
    chk("rst.state", buf_state, BUF_EMPTY);
    @(negedge rd_clk);
    rst_n = 1'b1;

    // Three preloaded words, m_ready high: 3 reads, data 2 cycles after first read
    step("t1_0", 1, 0, 8'h00, 0, BUF_EMPTY);
    step("t1_1", 1, 0, 8'h00, 0, BUF_EMPTY);
    step("t1_2", 1, 1, 8'h11, 0, BUF_ONE);
    step("t1_3", 0, 1, 8'h22, 1, BUF_ONE);
    step("t1_4", 0, 1, 8'h33, 2, BUF_ONE);
    step("t1_5", 0, 0, 8'h00, 3, BUF_EMPTY);

    // Back-pressure: only two reads, head holds, then drain with no gaps
    m_if.m_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    step("t2_0", 1, 0, 8'h00, 3, BUF_EMPTY);
    step("t2_1", 1, 0, 8'h00, 3, BUF_EMPTY);
    step("t2_2", 0, 1, 8'hA1, 3, BUF_ONE);
    step("t2_3", 0, 1, 8'hA1, 3, BUF_TWO);
    m_if.m_ready = 1'b1;
    step("t2_4", 1, 1, 8'hA1, 3, BUF_TWO);
    step("t2_5", 1, 1, 8'hA2, 4, -1);
    step("t2_6", 1, 1, 8'hA3, 5, -1);
    step("t2_7", 0, 1, 8'hA4, 6, -1);
    step("t2_8", 0, 1, 8'hA5, 7, -1);
    step("t2_9", 0, 0, 8'h00, 8, BUF_EMPTY);

    // m_ready toggling with a deep FIFO: order preserved, five beats in 11 cycles
    for (int i = 0; i < 8; i++) push(8'(8'hB0 + i));
    k = 0;
    for (int c = 0; c < 11; c++) begin
      m_if.m_ready = (c % 2 == 0);
      #1;
      if (m_if.m_valid && m_if.m_ready) begin
        chk("t3.data", m_if.m_data, 8'(8'hB0 + k));
        k++;
      end
      @(negedge rd_clk);
    end
    chk("t3.beats", k, 5);

    // Flush with one word buffered and one in flight: both dropped
    flush = 1'b1;
    m_if.m_ready = 1'b0;
    step("fl1_0", 0, 1, 8'hB5, 13, BUF_ONE);
    flush = 1'b0;
    m_if.m_ready = 1'b1;
    step("fl1_1", 1, 0, 8'h00, 13, BUF_EMPTY);
    step("fl1_2", 0, 0, 8'h00, 13, BUF_EMPTY);
    step("fl1_3", 0, 1, 8'hB7, 13, BUF_ONE);
    step("fl1_4", 0, 0, 8'h00, 14, BUF_EMPTY);

    // Flush with the buffer full and a pop in the same cycle: the pop counts
    m_if.m_ready = 1'b0;
    push(8'hC0); push(8'hC1); push(8'hC2);
    step("fl2_0", 1, 0, 8'h00, 14, BUF_EMPTY);
    step("fl2_1", 1, 0, 8'h00, 14, BUF_EMPTY);
    step("fl2_2", 0, 1, 8'hC0, 14, BUF_ONE);
    flush = 1'b1;
    m_if.m_ready = 1'b1;
    step("fl2_3", 0, 1, 8'hC0, 14, BUF_TWO);
    flush = 1'b0;
    step("fl2_4", 1, 0, 8'h00, 15, BUF_EMPTY);
    step("fl2_5", 0, 0, 8'h00, 15, BUF_EMPTY);
    step("fl2_6", 0, 1, 8'hC2, 15, BUF_ONE);
    step("fl2_7", 0, 0, 8'h00, 16, BUF_EMPTY);

    // Asynchronous reset mid-stream, then resume from the FIFO head
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5);
    step("r_0", 1, 0, 8'h00, 16, -1);
    step("r_1", 1, 0, 8'h00, 16, -1);
    step("r_2", 1, 1, 8'hD0, 16, -1);
    #1;
    chk("r_3.data", m_if.m_data, 8'hD1);
    rst_n = 1'b0;
    #1;
    chk("rstm.rd_en", fifo_rd_en, 1'b0);
    chk("rstm.valid", m_if.m_valid, 1'b0);
    chk("rstm.data", m_if.m_data, 8'h00);
    chk("rstm.last", m_if.m_last, 1'b0);
    chk("rstm.beat", beat_cnt, 16'd0);
    chk("rstm.state", buf_state, BUF_EMPTY);
    @(negedge rd_clk); @(negedge rd_clk);
    rst_n = 1'b1;
    step("q_0", 1, 0, 8'h00, 0, BUF_EMPTY);
    step("q_1", 1, 0, 8'h00, 0, BUF_EMPTY);
    step("q_2", 1, 1, 8'hD3, 0, BUF_ONE);
    step("q_3", 0, 1, 8'hD4, 1, BUF_ONE);
    step("q_4", 0, 1, 8'hD5, 2, BUF_ONE);
    step("q_5", 0, 0, 8'h00, 3, BUF_EMPTY);

`ifdef FIFO_RD_STREAM_LAST_EN
    // PKT_LEN=4: m_last on beats 4 and 8 of a fresh stream
    rst_n = 1'b0;
    @(negedge rd_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'hE0 + i));
    k = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m_if.m_valid && m_if.m_ready) begin
        k++;
        chk("last8.data", m_if.m_data, 8'(8'hE0 + k - 1));
        chk("last8.last", m_if.m_last, (k == 4) || (k == 8));
      end
      @(negedge rd_clk);
    end
    chk("last8.beats", k, 8);

    // Flush after beat 2 restarts the packet index
    for (int i = 0; i < 8; i++) push(8'(8'hF0 + i));
    k = 0;
    post = 0;
    flushed = 1'b0;
    for (int c = 0; c < 30 && post < 4; c++) begin
      if (k == 2 && !flushed) begin
        flush = 1'b1;
        m_if.m_ready = 1'b0;
        flushed = 1'b1;
      end else begin
        flush = 1'b0;
        m_if.m_ready = 1'b1;
      end
      #1;
      if (m_if.m_valid && m_if.m_ready) begin
        if (!flushed) begin
          k++;
          chk("lastf.pre", m_if.m_last, 1'b0);
        end else begin
          post++;
          chk("lastf.post", m_if.m_last, post == 4);
        end
      end
      @(negedge rd_clk);
    end
    flush = 1'b0;
    chk("lastf.beats", post, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
